// File: rtl/id_ex_operand_stage_pkg.sv
// Shared pipeline package for the ID/EX operand stage.
// Holds the datapath widths, the ALU control encodings and the
// bubble value loaded into the EX control register.
package riscv_pipe_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALUC_WIDTH     = 4;

  // ALUC[3] selects arithmetic shift and ALUC[2] selects right shift.
  // The ALU consumes only EX_B[4:0] as the shift amount.
  localparam int ALUC_ARITH_BIT = 3;
  localparam int ALUC_RIGHT_BIT = 2;

  typedef enum logic [ALUC_WIDTH-1:0] {
    ALUC_ADD = 4'b0000,
    ALUC_SUB = 4'b0001,
    ALUC_SLL = 4'b0010,
    ALUC_SRL = 4'b0100,
    ALUC_SRA = 4'b1100
  } aluc_e;

  // Control bits of the instruction held in EX.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
  } ex_ctrl_t;

  // A bubble carries no side effects and zero data.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode-side, forwarding-source and execute-side signals of
// the ID/EX operand stage.
//   master: drives decode/forwarding/control inputs, observes EX outputs
//   slave : the stage itself
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH     = riscv_pipe_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = riscv_pipe_pkg::REG_ADDR_WIDTH,
  parameter int ALUC_WIDTH     = riscv_pipe_pkg::ALUC_WIDTH
);
  logic                      STALL, FLUSH;
  logic                      ID_VALID;
  logic [REG_ADDR_WIDTH-1:0] ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic [DATA_WIDTH-1:0]     ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic                      ID_ALUSRC_IMM;
  logic [ALUC_WIDTH-1:0]     ID_ALUC;
  logic                      ID_REG_WRITE, ID_MEM_READ;
  logic [DATA_WIDTH-1:0]     EX_RESULT;
  logic [REG_ADDR_WIDTH-1:0] MEM_RD_ADDR, WB_RD_ADDR;
  logic                      MEM_REG_WRITE, WB_REG_WRITE;
  logic [DATA_WIDTH-1:0]     MEM_RESULT, WB_RESULT;
  logic                      EX_VALID;
  logic [DATA_WIDTH-1:0]     EX_A, EX_B, EX_STORE_DATA;
  logic [ALUC_WIDTH-1:0]     EX_ALUC;
  logic [REG_ADDR_WIDTH-1:0] EX_RD_ADDR;
  logic                      EX_REG_WRITE, EX_MEM_READ;
  logic                      LOAD_USE_HAZ;

  modport master (
    output STALL, FLUSH, ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_DATA,
           ID_RS2_DATA, ID_IMM, ID_ALUSRC_IMM, ID_ALUC, ID_RD_ADDR,
           ID_REG_WRITE, ID_MEM_READ, EX_RESULT, MEM_RD_ADDR, MEM_REG_WRITE,
           MEM_RESULT, WB_RD_ADDR, WB_REG_WRITE, WB_RESULT,
    input  EX_VALID, EX_A, EX_B, EX_STORE_DATA, EX_ALUC, EX_RD_ADDR,
           EX_REG_WRITE, EX_MEM_READ, LOAD_USE_HAZ
  );

  modport slave (
    input  STALL, FLUSH, ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_DATA,
           ID_RS2_DATA, ID_IMM, ID_ALUSRC_IMM, ID_ALUC, ID_RD_ADDR,
           ID_REG_WRITE, ID_MEM_READ, EX_RESULT, MEM_RD_ADDR, MEM_REG_WRITE,
           MEM_RESULT, WB_RD_ADDR, WB_REG_WRITE, WB_RESULT,
    output EX_VALID, EX_A, EX_B, EX_STORE_DATA, EX_ALUC, EX_RD_ADDR,
           EX_REG_WRITE, EX_MEM_READ, LOAD_USE_HAZ
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// operand_fwd_mux: resolves one source operand.
// Priority EX > MEM > WB > register file; register 0 always reads 0.
//   src      : source register index
//   ex_en    : EX stage may forward (valid, writes, not a load)
//   *_rd/*_we/*_data : destination, write enable, result per stage
//   rf_data  : register-file read value
//   operand  : resolved value
module operand_fwd_mux #(
  parameter int DATA_WIDTH     = riscv_pipe_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = riscv_pipe_pkg::REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic                      ex_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  input  logic                      mem_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  output logic [DATA_WIDTH-1:0]     operand
);
  always_comb begin
    operand = rf_data;
    if (src == '0)                       operand = '0;
    else if (ex_en  && (ex_rd  == src))  operand = ex_data;
    else if (mem_we && (mem_rd == src))  operand = mem_data;
    else if (wb_we  && (wb_rd  == src))  operand = wb_data;
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register for the ALU.
// Resolves rs1/rs2 through the forwarding network, selects immediate or
// rs2 for operand B, detects load-use hazards and applies
// reset / flush / stall / bubble to the EX register.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : slave side of id_ex_operand_stage_if
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = riscv_pipe_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = riscv_pipe_pkg::REG_ADDR_WIDTH,
  parameter int ALUC_WIDTH     = riscv_pipe_pkg::ALUC_WIDTH
) (
  input logic                  CLK,
  input logic                  RST,
  id_ex_operand_stage_if.slave bus
);
  import riscv_pipe_pkg::*;

  ex_ctrl_t                  ctrl_q;
  logic [DATA_WIDTH-1:0]     a_q, b_q, sd_q;
  logic [ALUC_WIDTH-1:0]     aluc_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
  logic                  ex_fwd_en, load_use;

  // A load's result does not exist yet in EX, so EX never forwards it.
  assign ex_fwd_en = ctrl_q.valid & ctrl_q.reg_write & ~ctrl_q.mem_read;

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .src(bus.ID_RS1_ADDR), .ex_en(ex_fwd_en), .ex_rd(rd_q), .ex_data(bus.EX_RESULT),
    .mem_we(bus.MEM_REG_WRITE), .mem_rd(bus.MEM_RD_ADDR), .mem_data(bus.MEM_RESULT),
    .wb_we(bus.WB_REG_WRITE), .wb_rd(bus.WB_RD_ADDR), .wb_data(bus.WB_RESULT),
    .rf_data(bus.ID_RS1_DATA), .operand(rs1_fwd)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .src(bus.ID_RS2_ADDR), .ex_en(ex_fwd_en), .ex_rd(rd_q), .ex_data(bus.EX_RESULT),
    .mem_we(bus.MEM_REG_WRITE), .mem_rd(bus.MEM_RD_ADDR), .mem_data(bus.MEM_RESULT),
    .wb_we(bus.WB_REG_WRITE), .wb_rd(bus.WB_RD_ADDR), .wb_data(bus.WB_RESULT),
    .rf_data(bus.ID_RS2_DATA), .operand(rs2_fwd)
  );

  // rs2 only matters for the hazard when it feeds operand B.
  assign load_use = bus.ID_VALID & ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) &
                    ((rd_q == bus.ID_RS1_ADDR) |
                     ((rd_q == bus.ID_RS2_ADDR) & ~bus.ID_ALUSRC_IMM));

  // Reset and flush beat stall; stall beats the hazard bubble.
  always_ff @(posedge CLK) begin
    if (RST || bus.FLUSH || (!bus.STALL && load_use)) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      a_q    <= '0;
      b_q    <= '0;
      sd_q   <= '0;
      aluc_q <= '0;
      rd_q   <= '0;
    end else if (!bus.STALL) begin
      ctrl_q <= '{valid:     bus.ID_VALID,
                  reg_write: bus.ID_VALID & bus.ID_REG_WRITE,
                  mem_read:  bus.ID_VALID & bus.ID_MEM_READ};
      a_q    <= rs1_fwd;
      b_q    <= bus.ID_ALUSRC_IMM ? bus.ID_IMM : rs2_fwd;
      sd_q   <= rs2_fwd;
      aluc_q <= bus.ID_ALUC;
      rd_q   <= bus.ID_RD_ADDR;
    end
  end

  assign bus.EX_VALID      = ctrl_q.valid;
  assign bus.EX_REG_WRITE  = ctrl_q.reg_write;
  assign bus.EX_MEM_READ   = ctrl_q.mem_read;
  assign bus.EX_A          = a_q;
  assign bus.EX_B          = b_q;
  assign bus.EX_STORE_DATA = sd_q;
  assign bus.EX_ALUC       = aluc_q;
  assign bus.EX_RD_ADDR    = rd_q;
  assign bus.LOAD_USE_HAZ  = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: a directed vector table followed by
// randomized traffic checked against a behavioural model.
module tb_id_ex_operand_stage;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();
  id_ex_operand_stage dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    logic        rst, stall, flush, id_valid, alusrc, rw, mr, mem_we, wb_we;
    logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, imm, ex_result, mem_result, wb_result;
    logic [3:0]  aluc;
    logic        chk_haz, haz;
    logic        e_valid, e_rw, e_mr;
    logic [31:0] e_a, e_b, e_sd;
    logic [3:0]  e_aluc;
    logic [4:0]  e_rd;
  } vec_t;

  typedef struct {
    logic        valid, rw, mr;
    logic [31:0] a, b, sd;
    logic [3:0]  aluc;
    logic [4:0]  rd;
  } ex_t;

  int   n_cmp = 0, n_bad = 0;
  vec_t tbl[$];
  ex_t  m, nxt;

  function automatic vec_t nv();
    vec_t v;
    v = '{default: '0};
    v.chk_haz = 1'b1;
    return v;
  endfunction

  function automatic ex_t zero_ex();
    ex_t e;
    e = '{default: '0};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst               = v.rst;
    bus.STALL         = v.stall;
    bus.FLUSH         = v.flush;
    bus.ID_VALID      = v.id_valid;
    bus.ID_RS1_ADDR   = v.rs1;
    bus.ID_RS2_ADDR   = v.rs2;
    bus.ID_RS1_DATA   = v.rs1_data;
    bus.ID_RS2_DATA   = v.rs2_data;
    bus.ID_IMM        = v.imm;
    bus.ID_ALUSRC_IMM = v.alusrc;
    bus.ID_ALUC       = v.aluc;
    bus.ID_RD_ADDR    = v.rd;
    bus.ID_REG_WRITE  = v.rw;
    bus.ID_MEM_READ   = v.mr;
    bus.EX_RESULT     = v.ex_result;
    bus.MEM_RD_ADDR   = v.mem_rd;
    bus.MEM_REG_WRITE = v.mem_we;
    bus.MEM_RESULT    = v.mem_result;
    bus.WB_RD_ADDR    = v.wb_rd;
    bus.WB_REG_WRITE  = v.wb_we;
    bus.WB_RESULT     = v.wb_result;
  endtask

  task automatic check_out(input string tag, input ex_t e);
    chk({tag, ".valid"}, bus.EX_VALID, e.valid);
    chk({tag, ".a"},     bus.EX_A, e.a);
    chk({tag, ".b"},     bus.EX_B, e.b);
    chk({tag, ".sd"},    bus.EX_STORE_DATA, e.sd);
    chk({tag, ".aluc"},  bus.EX_ALUC, e.aluc);
    chk({tag, ".rd"},    bus.EX_RD_ADDR, e.rd);
    chk({tag, ".rw"},    bus.EX_REG_WRITE, e.rw);
    chk({tag, ".mr"},    bus.EX_MEM_READ, e.mr);
  endtask

  // Reference: the first enabled producer whose destination matches wins,
  // scanning youngest to oldest; x0 is hard-wired to zero.
  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf, input vec_t v);
    logic        en[3];
    logic [4:0]  ad[3];
    logic [31:0] d[3];
    en = '{m.valid && m.rw && !m.mr, v.mem_we, v.wb_we};
    ad = '{m.rd, v.mem_rd, v.wb_rd};
    d  = '{v.ex_result, v.mem_result, v.wb_result};
    if (src == 0) return 32'h0;
    for (int k = 0; k < 3; k++) if (en[k] && ad[k] == src) return d[k];
    return rf;
  endfunction

  function automatic logic ref_haz(input vec_t v);
    logic uses;
    uses = (m.rd == v.rs1) || (m.rd == v.rs2 && !v.alusrc);
    return v.id_valid && m.valid && m.mr && m.rd != 0 && uses;
  endfunction

  initial begin
    vec_t v;
    ex_t  e;
    logic h;

    // reset, with live inputs
    v = nv(); v.rst = 1; v.id_valid = 1; v.rs1 = 3; v.rs1_data = 32'h5; v.rw = 1; v.rd = 4;
    v.chk_haz = 0; tbl.push_back(v);
    v = nv(); v.rst = 1; v.stall = 1; v.id_valid = 1; v.mr = 1; v.rd = 2; tbl.push_back(v);
    // producer of r5 enters EX
    v = nv(); v.id_valid = 1; v.rd = 5; v.rw = 1; v.alusrc = 1; v.imm = 32'h77; v.aluc = 4'h2;
    v.e_valid = 1; v.e_b = 32'h77; v.e_rd = 5; v.e_rw = 1; v.e_aluc = 4'h2; tbl.push_back(v);
    // EX forward beats the register file
    v = nv(); v.id_valid = 1; v.rs1 = 5; v.rs2 = 5; v.rs1_data = 32'h1234; v.rs2_data = 32'h1234;
    v.ex_result = 32'hAA; v.rd = 7; v.rw = 1;
    v.e_valid = 1; v.e_a = 32'hAA; v.e_b = 32'hAA; v.e_sd = 32'hAA; v.e_rd = 7; v.e_rw = 1; tbl.push_back(v);
    // EX/MEM/WB all write r7: EX wins, then MEM, then WB
    for (int k = 0; k < 3; k++) begin
      v = nv(); v.id_valid = 1; v.rs1 = 7; v.rs2 = 7; v.rs1_data = 32'h1234; v.rs2_data = 32'h1234;
      v.ex_result = 32'h1; v.mem_rd = 7; v.mem_we = (k != 2); v.mem_result = 32'h2;
      v.wb_rd = 7; v.wb_we = 1; v.wb_result = 32'h3; v.rw = (k == 2);
      v.e_valid = 1; v.e_a = k + 1; v.e_b = k + 1; v.e_sd = k + 1; v.e_rw = (k == 2);
      tbl.push_back(v);
    end
    // every stage writes x0: operands stay 0; a load of r9 enters EX
    v = nv(); v.id_valid = 1; v.ex_result = 32'h11; v.mem_we = 1; v.mem_result = 32'h22;
    v.wb_we = 1; v.wb_result = 32'h33; v.rs1_data = 32'h999; v.rs2_data = 32'h888;
    v.rd = 9; v.mr = 1; v.rw = 1;
    v.e_valid = 1; v.e_rd = 9; v.e_rw = 1; v.e_mr = 1; tbl.push_back(v);
    // load-use on rs2: one bubble, then MEM forward
    v = nv(); v.id_valid = 1; v.rs1 = 1; v.rs2 = 9; v.rs1_data = 32'h4; v.rs2_data = 32'h5;
    v.rd = 10; v.rw = 1; v.haz = 1; tbl.push_back(v);
    v.haz = 0; v.mem_rd = 9; v.mem_we = 1; v.mem_result = 32'hDEADBEEF;
    v.e_valid = 1; v.e_a = 32'h4; v.e_b = 32'hDEADBEEF; v.e_sd = 32'hDEADBEEF; v.e_rd = 10; v.e_rw = 1;
    tbl.push_back(v);
    // load again, then rs2=9 through the immediate path: no hazard
    v = nv(); v.id_valid = 1; v.rd = 9; v.mr = 1; v.rw = 1; v.alusrc = 1;
    v.e_valid = 1; v.e_rd = 9; v.e_rw = 1; v.e_mr = 1; tbl.push_back(v);
    v = nv(); v.id_valid = 1; v.rs1 = 2; v.rs1_data = 32'h20; v.rs2 = 9; v.rs2_data = 32'h30;
    v.alusrc = 1; v.imm = 32'h8; v.rd = 11; v.rw = 1;
    v.e_valid = 1; v.e_a = 32'h20; v.e_b = 32'h8; v.e_sd = 32'h30; v.e_rd = 11; v.e_rw = 1; tbl.push_back(v);
    // A=0x10 captured, held across three stalls, then flush+stall bubbles
    v = nv(); v.id_valid = 1; v.rs1 = 3; v.rs1_data = 32'h10; v.alusrc = 1; v.rd = 12; v.rw = 1; v.aluc = 4'hC;
    v.e_valid = 1; v.e_a = 32'h10; v.e_rd = 12; v.e_rw = 1; v.e_aluc = 4'hC; tbl.push_back(v);
    for (int k = 0; k < 3; k++) begin
      v.stall = 1; v.rs1_data = 32'h99 + k; v.rd = 13 + k; v.mr = (k == 1); v.imm = k;
      tbl.push_back(v);
    end
    v = nv(); v.stall = 1; v.flush = 1; v.id_valid = 1; v.rs1 = 3; v.rs1_data = 32'h77; v.rw = 1; v.rd = 6;
    tbl.push_back(v);
    // immediate B, forwarded rs2 as store data
    v = nv(); v.id_valid = 1; v.rs2 = 4; v.mem_rd = 4; v.mem_we = 1; v.mem_result = 32'h55;
    v.alusrc = 1; v.imm = 32'hFFFFFFFC; v.rd = 1; v.rw = 1;
    v.e_valid = 1; v.e_b = 32'hFFFFFFFC; v.e_sd = 32'h55; v.e_rd = 1; v.e_rw = 1; tbl.push_back(v);
    // invalid capture masks write/read enables
    v = nv(); v.rw = 1; v.mr = 1; v.rd = 3; v.imm = 32'h5; v.alusrc = 1; v.aluc = 4'h4;
    v.e_b = 32'h5; v.e_rd = 3; v.e_aluc = 4'h4; tbl.push_back(v);

    v = nv(); v.rst = 1; drive(v);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk_haz) chk($sformatf("v%0d.haz", i), bus.LOAD_USE_HAZ, tbl[i].haz);
      @(posedge clk);
      #1;
      e.valid = tbl[i].e_valid; e.rw = tbl[i].e_rw; e.mr = tbl[i].e_mr;
      e.a = tbl[i].e_a; e.b = tbl[i].e_b; e.sd = tbl[i].e_sd;
      e.aluc = tbl[i].e_aluc; e.rd = tbl[i].e_rd;
      check_out($sformatf("v%0d", i), e);
    end

    // randomized traffic against the model, starting from reset
    m = zero_ex();
    for (int c = 0; c < 3000; c++) begin
      v = nv();
      v.rst      = (c == 0) || ($urandom_range(0, 39) == 0);
      v.stall    = ($urandom_range(0, 5) == 0);
      v.flush    = ($urandom_range(0, 11) == 0);
      v.id_valid = ($urandom_range(0, 7) != 0);
      v.rs1 = $urandom_range(0, 3); v.rs2 = $urandom_range(0, 3); v.rd = $urandom_range(0, 3);
      v.mem_rd = $urandom_range(0, 3); v.wb_rd = $urandom_range(0, 3);
      v.rs1_data = $urandom; v.rs2_data = $urandom; v.imm = $urandom;
      v.ex_result = $urandom; v.mem_result = $urandom; v.wb_result = $urandom;
      v.alusrc = $urandom_range(0, 1); v.rw = $urandom_range(0, 1);
      v.mr = ($urandom_range(0, 2) == 0); v.mem_we = $urandom_range(0, 1);
      v.wb_we = $urandom_range(0, 1); v.aluc = $urandom_range(0, 15);
      @(negedge clk);
      drive(v);
      #1;
      h = ref_haz(v);
      chk($sformatf("r%0d.haz", c), bus.LOAD_USE_HAZ, h);
      if (v.rst || v.flush || (!v.stall && h)) nxt = zero_ex();
      else if (v.stall) nxt = m;
      else begin
        nxt.valid = v.id_valid;
        nxt.rw    = v.id_valid && v.rw;
        nxt.mr    = v.id_valid && v.mr;
        nxt.a     = ref_fwd(v.rs1, v.rs1_data, v);
        nxt.sd    = ref_fwd(v.rs2, v.rs2_data, v);
        nxt.b     = v.alusrc ? v.imm : nxt.sd;
        nxt.aluc  = v.aluc;
        nxt.rd    = v.rd;
      end
      @(posedge clk);
      #1;
      m = nxt;
      check_out($sformatf("r%0d", c), m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage feeding the 32-bit ALU. Each cycle it resolves both source operands through a forwarding network and selects immediate or register operand B. It registers the operands and ALU control into the execute stage. It also detects load-use hazards and handles stall, flush and bubble insertion, so the ALU always receives fully resolved A/B/ALUC one cycle after decode.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, register index width
- ALUC_WIDTH, 4, ALU control width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- STALL  in  1  downstream hold; register keeps its contents
- FLUSH  in  1  squash; next state is a bubble
- ID_VALID  in  1  decode slot holds a real instruction
- ID_RS1_ADDR, ID_RS2_ADDR  in  REG_ADDR_WIDTH  source indices
- ID_RS1_DATA, ID_RS2_DATA  in  DATA_WIDTH  register-file read data
- ID_IMM  in  DATA_WIDTH  sign/zero-extended immediate
- ID_ALUSRC_IMM  in  1  1: B = ID_IMM, 0: B = forwarded rs2
- ID_ALUC  in  ALUC_WIDTH  ALU control, passed through
- ID_RD_ADDR  in  REG_ADDR_WIDTH  destination index
- ID_REG_WRITE, ID_MEM_READ  in  1  writes rd / is a load
- EX_RESULT  in  DATA_WIDTH  ALU OUT of the instruction now in EX
- MEM_RD_ADDR  in  REG_ADDR_WIDTH  destination of the instruction in MEM
- MEM_REG_WRITE  in  1  write enable of the instruction in MEM
- MEM_RESULT  in  DATA_WIDTH  result of the instruction in MEM
- WB_RD_ADDR  in  REG_ADDR_WIDTH  destination of the instruction in WB
- WB_REG_WRITE  in  1  write enable of the instruction in WB
- WB_RESULT  in  DATA_WIDTH  result of the instruction in WB
- EX_VALID  out  1  registered instruction is real
- EX_A, EX_B  out  DATA_WIDTH  ALU operands
- EX_STORE_DATA  out  DATA_WIDTH  forwarded rs2, for stores
- EX_ALUC  out  ALUC_WIDTH  ALU control
- EX_RD_ADDR  out  REG_ADDR_WIDTH  destination
- EX_REG_WRITE, EX_MEM_READ  out  1  registered controls
- LOAD_USE_HAZ  out  1  combinational; upstream must hold PC and IF/ID

## Operation
- Forwarding is applied per source; src is the source index.
  - Priority: EX > MEM > WB > register file.
  - EX hit: EX_VALID & EX_REG_WRITE & !EX_MEM_READ & EX_RD_ADDR==src.
  - MEM hit: MEM_REG_WRITE & MEM_RD_ADDR==src.
  - WB hit: WB_REG_WRITE & WB_RD_ADDR==src.
  - src==0 never forwards; the operand is 0.
- LOAD_USE_HAZ = ID_VALID & EX_VALID & EX_MEM_READ & EX_RD_ADDR!=0 & (EX_RD_ADDR==ID_RS1_ADDR | (EX_RD_ADDR==ID_RS2_ADDR & !ID_ALUSRC_IMM)).
- Next-state priority, evaluated at each edge:
  1. RST → all outputs 0.
  2. FLUSH → bubble.
  3. STALL → hold all registers.
  4. LOAD_USE_HAZ → bubble.
  5. Otherwise capture: EX_VALID=ID_VALID, EX_A=fwd(rs1), EX_B=ID_ALUSRC_IMM?ID_IMM:fwd(rs2), EX_STORE_DATA=fwd(rs2), controls copied.
- Bubble: EX_VALID=0, EX_REG_WRITE=0, EX_MEM_READ=0, all data fields and EX_ALUC 0.
- Capture with ID_VALID=0 forces EX_REG_WRITE=0 and EX_MEM_READ=0.
- No arithmetic: width-preserving muxing only.
- Shift amount reaches the ALU as EX_B[4:0]; upper bits are ignored downstream.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on outputs after edge N.
- Reset is synchronous. All outputs read 0 from the first edge with RST high. LOAD_USE_HAZ is 0 while EX_VALID=0.
- RST or FLUSH asserted mid-stall takes effect at that edge; the held instruction is discarded.
- STALL and LOAD_USE_HAZ together: hold wins. The hazard is re-evaluated after STALL drops.
- A load-use bubble lasts exactly one cycle. On the following edge the load has moved to MEM and is forwarded from MEM_RESULT.
- FLUSH and LOAD_USE_HAZ together: bubble. LOAD_USE_HAZ remains a combinational output; the upstream flush overrides it.

## Structure
- Shared package `riscv_pipe_pkg`: DATA_WIDTH, REG_ADDR_WIDTH, ALUC_WIDTH constants; ALUC encodings (ALUC[3] arithmetic shift, ALUC[2] right shift); a bubble-value constant.
- One sub-module, `operand_fwd_mux`: 4-source priority forward with the x0 rule. It is instantiated twice (rs1, rs2).
- Top level holds the hazard compare, the ALUSRC select and the pipeline register.

## Test plan
- Reset: RST=1 for 2 cycles with random inputs → all outputs 0, LOAD_USE_HAZ=0.
- EX forward: EX instr rd=5, result 0x0000_00AA; ID rs1=5, rs2=5, ALUSRC=0 → EX_A=EX_B=0xAA next cycle, ignoring regfile 0x1234.
- Priority: EX/MEM/WB all write rd=7 with 1/2/3 → operand=1. EX not writing → 2. Only WB writing → 3. rs1=0 with all writing rd=0 → 0.
- Load-use: EX holds a load with rd=9; ID reads rs2=9, ALUSRC=0 → LOAD_USE_HAZ=1, bubble (EX_VALID=0). Next cycle MEM_RESULT=0xDEAD_BEEF → EX_B=0xDEADBEEF. With ALUSRC=1 and rs2=9 → no hazard.
- Stall/flush: EX holds A=0x10. Apply STALL 3 cycles with changing inputs → A stays 0x10. Then FLUSH+STALL together → bubble.
- Immediate path: ID_IMM=0xFFFF_FFFC, ALUSRC=1, rs2 forwarded 0x55 → EX_B=0xFFFFFFFC, EX_STORE_DATA=0x55.
